dbg_run_ctrl: RTL
=================

// Module: dbg_run_ctrl
// PURPOSE
//  Debug run-control unit for the RV32I core; replaces the free-running halt/clock-gate and readout mux.
//  Sits between the top level and the datapath. Produces a clock-enable (no gated clock) and halts on
//  ecall/halt decode, debugger request or PC breakpoints. Supports single-step and resume.
//  While halted, serves debugger word reads from data memory over a req/ack handshake.
// PARAMETERS
//  XLEN          32  datapath / PC / data width
//  ADDR_W        8   debugger byte-address width; word index = rd_addr >> 2
//  NUM_BP        4   number of PC breakpoint channels (1..16)
//  RD_LAT        1   data-memory read latency in cycles (>=1)
//  RESET_HALTED  0   1: leave reset in HALTED (cause RESET); 0: leave reset in RUN
// PORTS
//  clk          in   1         core clock
//  rst          in   1         asynchronous, active-low reset
//  core_hlt     in   1         halt-instruction decode from controller (level)
//  pc           in   XLEN      PC of instruction presented this cycle
//  dbg_halt_req in   1         debugger halt request (pulse or level)
//  dbg_resume   in   1         debugger resume (1-cycle pulse)
//  dbg_step     in   1         debugger single-step (1-cycle pulse)
//  bp_wr_en     in   1         breakpoint table write strobe
//  bp_wr_idx    in   clog2(NUM_BP)  channel index
//  bp_wr_addr   in   XLEN      breakpoint PC
//  bp_wr_vld    in   1         channel enable written with bp_wr_addr
//  rd_req       in   1         debugger read request; held until rd_ack
//  rd_addr      in   ADDR_W    byte address, sampled when request accepted
//  rd_ack       out  1         1-cycle read completion
//  rd_err       out  1         with rd_ack: request refused (core not halted)
//  rd_data      out  XLEN      read data, registered, held until next completion
//  mem_rd_en    out  1         1-cycle read strobe to data memory
//  mem_rd_addr  out  ADDR_W-2  word index to data memory
//  mem_rd_data  in   XLEN      data memory read data, valid RD_LAT cycles after mem_rd_en
//  core_result  in   XLEN      datapath result bus
//  core_ce      out  1         core clock-enable: all core state updates only when 1
//  halted       out  1         1 in HALTED
//  halt_cause   out  3         cause of last halt (package codes)
//  result_out   out  XLEN      halted ? rd_data : core_result
// BEHAVIOUR
//  Reset (rst=0, async): state RUN (or HALTED if RESET_HALTED), cause RESET, all bp_vld=0, rd_ack=0,
//   rd_err=0, rd_data=0, mem_rd_en=0, read FSM IDLE, skip_bp=0.
//  Run FSM states: RUN, HALTED, STEP.
//  RUN: hit = |(bp_vld[i] & pc==bp_addr[i]) & ~skip_bp. core_ce = ~(hit|core_hlt|dbg_halt_req), combinational.
//   Any of those -> HALTED next cycle; the instruction at pc is NOT executed. Cause priority HLT > BP > DBG.
//   skip_bp clears after the first RUN cycle.
//  HALTED: core_ce=0. dbg_resume -> RUN with skip_bp=1 (resume from a breakpoint executes it once).
//   dbg_step -> STEP with skip_bp=1. Resume beats step if same cycle. Both ignored while
//   core_hlt=1 and cause=HLT (halt instruction is terminal) and while the read FSM is busy (dropped, not queued).
//  STEP: core_ce=1 for exactly one cycle, then HALTED, cause STEP; core_hlt in STEP -> cause HLT, ce=0.
//  dbg_halt_req in HALTED/STEP: no effect beyond STEP completing normally.
//  Breakpoint writes: any state; visible from the next cycle; write to matching pc same cycle does not hit.
//  Read FSM IDLE/WAIT: rd_req in IDLE while halted -> mem_rd_en=1, mem_rd_addr=rd_addr>>2, WAIT;
//   counter runs RD_LAT cycles, then capture mem_rd_data into rd_data, rd_ack=1, back to IDLE.
//   Read latency request-to-ack = RD_LAT+1 cycles. rd_req while not halted -> rd_ack=1, rd_err=1 next cycle,
//   rd_data unchanged. Requester drops rd_req the cycle after rd_ack; a held rd_req re-issues.
//  Async reset mid-read aborts it: no rd_ack.
// STRUCTURE
//  Package dbg_pkg: run-state encoding (RUN=0, HALTED=1, STEP=2); halt_cause codes RESET=0, DBG=1, BP=2, HLT=3, STEP=4.
//  Sub-module dbg_bp_match: NUM_BP-entry breakpoint table + parallel comparators -> hit.
//  Run FSM, read FSM and result mux in this module.
// TESTING
//  Reset: rst=0 mid-run -> halted=0, core_ce=1, halt_cause=0, rd_ack=0; RESET_HALTED=1 -> halted=1.
//  BP: bp[2]=0x40 valid, pc reaches 0x40 -> core_ce=0 that cycle, halted=1 next, cause=2; resume -> 0x40 executes once.
//  Step: halted, dbg_step pulse -> exactly one core_ce=1 cycle, then halted=1, cause=4.
//  Read: halted, mem[5]=0xDEADBEEF, rd_addr=0x14, RD_LAT=2 -> mem_rd_addr=5, rd_ack 3 cycles later, result_out=0xDEADBEEF.
//  Refused read: running, rd_req -> rd_ack=1, rd_err=1, rd_data unchanged, no mem_rd_en.
//  Simultaneous: core_hlt & bp hit & dbg_halt_req same cycle -> cause=3; later resume ignored while core_hlt=1.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug run-control unit.
//   run_state_e  : run FSM states (RUN=0, HALTED=1, STEP=2)
//   halt_cause_e : reason for the most recent halt, as seen by the debugger
//   rd_state_e   : debugger read FSM states
//   idx_width()  : index width that never collapses to zero bits
//   pick_cause() : halt-cause priority HLT > BP > DBG
package dbg_pkg;

    typedef enum logic [1:0] {
        RS_RUN    = 2'd0,
        RS_HALTED = 2'd1,
        RS_STEP   = 2'd2
    } run_state_e;

    typedef enum logic [2:0] {
        CAUSE_RESET = 3'd0,
        CAUSE_DBG   = 3'd1,
        CAUSE_BP    = 3'd2,
        CAUSE_HLT   = 3'd3,
        CAUSE_STEP  = 3'd4
    } halt_cause_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic halt_cause_e pick_cause(input logic hlt, input logic bp);
        if (hlt) begin
            return CAUSE_HLT;
        end
        if (bp) begin
            return CAUSE_BP;
        end
        return CAUSE_DBG;
    endfunction

endpackage

// File: rtl/dbg_run_ctrl_if.sv
// Debugger-facing bus of the run-control unit.
//   Run control : dbg_halt_req, dbg_resume, dbg_step
//   BP writes   : bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_vld
//   Word read   : rd_req/rd_addr (request), rd_ack/rd_err/rd_data (completion)
// master = debugger side, slave = dbg_run_ctrl side.
interface dbg_run_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 8,
    parameter int NUM_BP = 4
);
    import dbg_pkg::*;

    localparam int BP_IDX_W = idx_width(NUM_BP);

    logic                dbg_halt_req;
    logic                dbg_resume;
    logic                dbg_step;
    logic                bp_wr_en;
    logic [BP_IDX_W-1:0] bp_wr_idx;
    logic [XLEN-1:0]     bp_wr_addr;
    logic                bp_wr_vld;
    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_ack;
    logic                rd_err;
    logic [XLEN-1:0]     rd_data;

    modport master (
        output dbg_halt_req, dbg_resume, dbg_step,
        output bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_vld,
        output rd_req, rd_addr,
        input  rd_ack, rd_err, rd_data
    );

    modport slave (
        input  dbg_halt_req, dbg_resume, dbg_step,
        input  bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_vld,
        input  rd_req, rd_addr,
        output rd_ack, rd_err, rd_data
    );

endinterface

// File: rtl/dbg_bp_match.sv
// PC breakpoint table with parallel comparators.
//   clk, rst  : clock, asynchronous active-low reset (clears all enables)
//   wr_*_i    : table write port; a write is visible from the next cycle
//   pc_i      : PC to compare
//   hit_o     : some enabled channel matches pc_i
module dbg_bp_match #(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 4,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [XLEN-1:0]  wr_addr_i,
    input  logic             wr_vld_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             hit_o
);

    logic [NUM_BP-1:0] match;

    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
        logic [XLEN-1:0] addr_q;
        logic            vld_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                addr_q <= '0;
                vld_q  <= 1'b0;
            end else if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
                addr_q <= wr_addr_i;
                vld_q  <= wr_vld_i;
            end
        end

        assign match[gi] = vld_q && (addr_q == pc_i);
    end

    assign hit_o = |match;

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run-control unit for the RV32I core.
//   clk, rst     : core clock, asynchronous active-low reset
//   core_hlt     : halt-instruction decode (level)
//   pc           : PC of the instruction presented this cycle
//   dbg          : debugger bus (run control, breakpoint writes, word reads)
//   mem_rd_*     : data-memory read port, data valid RD_LAT cycles after mem_rd_en
//   core_result  : datapath result bus
//   core_ce      : core clock-enable, core state updates only when 1
//   halted       : unit is in HALTED
//   halt_cause   : cause of the last halt (halt_cause_e codes)
//   result_out   : rd_data while halted, core_result otherwise
module dbg_run_ctrl
    import dbg_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 8,
    parameter int NUM_BP       = 4,
    parameter int RD_LAT       = 1,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_hlt,
    input  logic [XLEN-1:0]   pc,
    dbg_run_ctrl_if.slave     dbg,
    output logic              mem_rd_en,
    output logic [ADDR_W-3:0] mem_rd_addr,
    input  logic [XLEN-1:0]   mem_rd_data,
    input  logic [XLEN-1:0]   core_result,
    output logic              core_ce,
    output logic              halted,
    output logic [2:0]        halt_cause,
    output logic [XLEN-1:0]   result_out
);

    localparam int              BP_IDX_W = idx_width(NUM_BP);
    localparam int              CNT_W    = idx_width(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    run_state_e       run_q, run_d;
    halt_cause_e      cause_q, cause_d;
    logic             skip_bp_q, skip_bp_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_ack_q, rd_ack_d;
    logic             rd_err_q, rd_err_d;
    logic [XLEN-1:0]  rd_data_q, rd_data_d;

    logic bp_hit_raw, bp_hit, halt_now, rd_accept, rd_busy, cmd_blocked;

    dbg_bp_match #(
        .XLEN   (XLEN),
        .NUM_BP (NUM_BP),
        .IDX_W  (BP_IDX_W)
    ) u_bp_match (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (dbg.bp_wr_en),
        .wr_idx_i  (dbg.bp_wr_idx),
        .wr_addr_i (dbg.bp_wr_addr),
        .wr_vld_i  (dbg.bp_wr_vld),
        .pc_i      (pc),
        .hit_o     (bp_hit_raw)
    );

    // After resume/step the breakpoint at the current PC must not re-fire,
    // otherwise the core could never move past it.
    assign bp_hit = bp_hit_raw & ~skip_bp_q;
    assign halted = (run_q == RS_HALTED);

    // Read FSM. The ack cycle is excluded from acceptance because the
    // requester only drops rd_req on the following cycle.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_ack_d   = 1'b0;
        rd_err_d   = 1'b0;
        rd_data_d  = rd_data_q;
        rd_accept  = 1'b0;
        mem_rd_en  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (dbg.rd_req && !rd_ack_q) begin
                    rd_accept = 1'b1;
                    if (halted) begin
                        mem_rd_en  = 1'b1;
                        rd_state_d = RD_WAIT;
                        rd_cnt_d   = CNT_LOAD;
                    end else begin
                        rd_ack_d = 1'b1;
                        rd_err_d = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_cnt_q == '0) begin
                    rd_data_d  = mem_rd_data;
                    rd_ack_d   = 1'b1;
                    rd_state_d = RD_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q - 1'b1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign mem_rd_addr = dbg.rd_addr[ADDR_W-1:2];
    // A read being launched this cycle already counts as busy so that a
    // resume cannot let the core run while memory is being read.
    assign rd_busy     = (rd_state_q == RD_WAIT) || (rd_accept && halted);

    // Run FSM.
    always_comb begin
        run_d       = run_q;
        cause_d     = cause_q;
        skip_bp_d   = skip_bp_q;
        core_ce     = 1'b0;
        halt_now    = 1'b0;
        cmd_blocked = (core_hlt && (cause_q == CAUSE_HLT)) || rd_busy;
        case (run_q)
            RS_RUN: begin
                halt_now  = bp_hit | core_hlt | dbg.dbg_halt_req;
                core_ce   = ~halt_now;
                skip_bp_d = 1'b0;
                if (halt_now) begin
                    run_d   = RS_HALTED;
                    cause_d = pick_cause(core_hlt, bp_hit);
                end
            end
            RS_HALTED: begin
                if (!cmd_blocked) begin
                    if (dbg.dbg_resume) begin
                        run_d     = RS_RUN;
                        skip_bp_d = 1'b1;
                    end else if (dbg.dbg_step) begin
                        run_d     = RS_STEP;
                        skip_bp_d = 1'b1;
                    end
                end
            end
            RS_STEP: begin
                run_d   = RS_HALTED;
                core_ce = ~core_hlt;
                cause_d = core_hlt ? CAUSE_HLT : CAUSE_STEP;
            end
            default: run_d = RS_HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= RESET_HALTED ? RS_HALTED : RS_RUN;
            cause_q    <= CAUSE_RESET;
            skip_bp_q  <= 1'b0;
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_ack_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            run_q      <= run_d;
            cause_q    <= cause_d;
            skip_bp_q  <= skip_bp_d;
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_ack_q   <= rd_ack_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign dbg.rd_ack  = rd_ack_q;
    assign dbg.rd_err  = rd_err_q;
    assign dbg.rd_data = rd_data_q;
    assign halt_cause  = cause_q;
    assign result_out  = halted ? rd_data_q : core_result;

endmodule
